memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline M stage between `execute` and writeback. Registers execute results (X/M register) and performs data-memory loads and stores through a req/ack handshake to the data memory, with big-endian byte-lane alignment and LB/LBU extension. Stalls upstream while an access is outstanding, supplies the MX bypass value, and presents registered results (M/W register) to writeback. A watchdog flags a data memory that never acknowledges.

## Interface
- `DM_TIMEOUT`, 255: ACCESS cycles without `dm_ack` before abort (1..255).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `in_valid`  in  1  execute presents a valid instruction.
- `in_insn`  in  32  instruction word.
- `in_alu`  in  32  execute `aluOut` (result or effective address).
- `in_rb`  in  32  execute `rBOut` (store data).
- `in_dmwe`, `in_rwe`, `in_rdst`, `in_rwd`, `in_dm_byte`, `in_unsigned`  in  1 each  store enable, reg write, dest select (1: insn[15:11], 0: insn[20:16]), writeback-from-memory, byte access, zero-extend byte load.
- `stall`  out  1  upstream must hold; X/M does not load.
- `dm_req`  out  1  access request.
- `dm_we`  out  1  write.
- `dm_addr`  out  32  word address (addr[1:0] forced 00).
- `dm_be`  out  4  byte enables, bit 3 = bits 31:24.
- `dm_wdata`  out  32  write data.
- `dm_ack`  in  1  access complete this cycle.
- `dm_rdata`  in  32  read data, valid when `dm_ack`.
- `mx_bypass`  out  32  M-stage ALU result; `mx_rd` out 5; `mx_rwe` out 1 (valid-qualified).
- `wb_valid`, `wb_rwe`  out  1 each; `wb_rd`  out  5; `wb_data`  out  32.
- `dm_err`  out  1  sticky: timeout occurred.
- `align_err`  out  1  sticky: misaligned word access.

## Operation
- Mem op = `m_dmwe | m_rwd`. Dest: `rdst` per above; opcode 6'b000011 (JAL) forces 31. `mx_rwe`/`wb_rwe` are 0 when dest is 0.
- X/M register loads all `in_*` when `!stall`; `m_valid <= in_valid`.
- FSM: IDLE, ACCESS.
  - IDLE, non-mem op valid: M/W captures `in_alu`-derived result next edge (1 cycle in M).
  - IDLE, mem op, word access with addr[1:0]≠00: no request; set `align_err`; retire with `wb_rwe=0`.
  - IDLE, aligned mem op: next state ACCESS at the same edge the op enters M (state computed from X/M load).
  - ACCESS: `dm_req=1`, `stall=1`, address/data/be stable. On edge with `dm_ack=1`: M/W captures, `m_valid<=0`, -> IDLE. Wait counter increments each ACCESS cycle without ack; on reaching `DM_TIMEOUT`: set `dm_err`, retire with `wb_rwe=0`, `m_valid<=0`, -> IDLE.
- `stall = (state==ACCESS)`.
- Stores: word `dm_be=1111`, `dm_wdata=rb`; byte `dm_be=4'b1000>>addr[1:0]`, `dm_wdata={4{rb[7:0]}}`. Loads use same `dm_be`, `dm_we=0`.
- Load data: word = `dm_rdata`; byte = lane `3-addr[1:0]`, sign-extended unless `m_unsigned`.
- `wb_data` = load data if `m_rwd`, else `m_alu`. Stores retire with `wb_rwe=0`.
- `dm_err`, `align_err` cleared only by reset.

## Timing
- Reset (async, low): state IDLE, counter 0, `m_valid=0`, all outputs 0 incl. `stall`, `dm_req`, flags. Reset during ACCESS drops the request immediately; instruction lost.
- Non-mem op: X/M at edge E0, W at E1.
- Mem op: X/M at E0, `dm_req` high from E0; ack in cycle k (k≥1) -> W at E0+k; `stall` drops after that edge; bubble in M for one cycle, next op loads at E0+k+1.
- `dm_ack` outside ACCESS ignored. `in_valid=0` loads a bubble; bubbles never request.
- `wb_*` valid for exactly one cycle per retired instruction.

## Test plan
- Reset: assert `reset=0` mid-ACCESS -> `dm_req`, `stall`, `wb_valid` 0 immediately; state IDLE after release.
- ALU passthrough: `in_alu=0x1234`, rwe=1, rdst=1, rd=5 -> after 1 edge `wb_valid=1`, `wb_rd=5`, `wb_data=0x1234`; `mx_bypass=0x1234` in M cycle.
- LW addr 0x100, ack after 3 cycles with 0xDEADBEEF -> `stall` 3 cycles, `dm_be=1111`, `wb_data=0xDEADBEEF`.
- LB/LBU addr 0x101, rdata 0x11F2_3344 -> LB `wb_data=0xFFFFFFF2`, LBU `0x000000F2`, `dm_be=0100`.
- SB addr 0x203, rb=0xAB -> `dm_addr=0x200`, `dm_be=0001`, `dm_wdata=0xABABABAB`, `dm_we=1`, `wb_rwe=0`; LW at 0x102 -> no `dm_req`, `align_err=1`.
- `DM_TIMEOUT=4`, no ack -> `dm_req` high 4 cycles, `dm_err=1`, retire `wb_rwe=0`, next instruction proceeds.

Source files
------------

// File: rtl/memory_stage.sv
// Pipeline M stage: X/M register, data-memory load/store access with byte-lane
// alignment and byte-load extension, MX bypass, M/W register and ack watchdog.
module memory_stage #(
    parameter int unsigned DM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_rb,
    input  logic        in_dmwe,
    input  logic        in_rwe,
    input  logic        in_rdst,
    input  logic        in_rwd,
    input  logic        in_dm_byte,
    input  logic        in_unsigned,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] mx_bypass,
    output logic [4:0]  mx_rd,
    output logic        mx_rwe,
    output logic        wb_valid,
    output logic        wb_rwe,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        dm_err,
    output logic        align_err,
    output logic        dbg_state
);

    // Data-memory handshake: dm_req is held high, with address, byte enables,
    // write enable and write data stable, until the cycle in which dm_ack is
    // high; that rising edge completes the access and dm_rdata is sampled
    // there. dm_ack is ignored whenever no request is outstanding.

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(DM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        m_valid_q, m_valid_d;
    logic [4:0]  m_rd_q, m_rd_d;
    logic [31:0] m_alu_q, m_alu_d;
    logic [31:0] m_rb_q, m_rb_d;
    logic        m_dmwe_q, m_dmwe_d;
    logic        m_rwe_q, m_rwe_d;
    logic        m_rwd_q, m_rwd_d;
    logic        m_dm_byte_q, m_dm_byte_d;
    logic        m_unsigned_q, m_unsigned_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_rwe_q, wb_rwe_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        dm_err_q, dm_err_d;
    logic        align_err_q, align_err_d;

    logic        in_mem, in_misaligned;
    logic [4:0]  in_rd;
    logic        m_mem, m_misaligned;
    logic        in_access;
    logic        acc_done, acc_timeout, retire_idle, retire;
    logic [7:0]  load_byte;
    logic [31:0] load_data;
    logic        unused_insn_bits;

    // Only the opcode and the two register fields matter past execute.
    assign unused_insn_bits = ^{in_insn[25:21], in_insn[10:0]};

    always_comb begin
        in_mem        = in_dmwe | in_rwd;
        in_misaligned = !in_dm_byte && (in_alu[1:0] != 2'b00);
        if (in_insn[31:26] == 6'b000011) begin
            in_rd = 5'd31;
        end else if (in_rdst) begin
            in_rd = in_insn[15:11];
        end else begin
            in_rd = in_insn[20:16];
        end
    end

    always_comb begin
        m_mem        = m_dmwe_q | m_rwd_q;
        m_misaligned = !m_dm_byte_q && (m_alu_q[1:0] != 2'b00);
        in_access    = (state_q == S_ACCESS);
        acc_done     = in_access && dm_ack;
        acc_timeout  = in_access && !dm_ack && (wait_cnt_q == TIMEOUT_LAST);
        // In IDLE an occupied M slot holds a non-memory op or a misaligned one.
        retire_idle  = !in_access && m_valid_q;
        retire       = retire_idle || acc_done || acc_timeout;
    end

    // Big-endian lanes: byte address 0 lives in bits 31:24.
    always_comb begin
        load_byte = 8'h00;
        case (m_alu_q[1:0])
            2'd0: load_byte = dm_rdata[31:24];
            2'd1: load_byte = dm_rdata[23:16];
            2'd2: load_byte = dm_rdata[15:8];
            2'd3: load_byte = dm_rdata[7:0];
            default: load_byte = 8'h00;
        endcase
        if (m_dm_byte_q) begin
            load_data = {{24{load_byte[7] & !m_unsigned_q}}, load_byte};
        end else begin
            load_data = dm_rdata;
        end
    end

    // FSM next state and wait counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = 8'd0;
                if (in_valid && in_mem && !in_misaligned) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (acc_done || acc_timeout) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // X/M register: frozen while an access is outstanding, emptied when it ends.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_rd_d       = m_rd_q;
        m_alu_d      = m_alu_q;
        m_rb_d       = m_rb_q;
        m_dmwe_d     = m_dmwe_q;
        m_rwe_d      = m_rwe_q;
        m_rwd_d      = m_rwd_q;
        m_dm_byte_d  = m_dm_byte_q;
        m_unsigned_d = m_unsigned_q;
        if (!in_access) begin
            m_valid_d    = in_valid;
            m_rd_d       = in_rd;
            m_alu_d      = in_alu;
            m_rb_d       = in_rb;
            m_dmwe_d     = in_dmwe;
            m_rwe_d      = in_rwe;
            m_rwd_d      = in_rwd;
            m_dm_byte_d  = in_dm_byte;
            m_unsigned_d = in_unsigned;
        end else if (acc_done || acc_timeout) begin
            m_valid_d = 1'b0;
        end
    end

    // M/W register and sticky error flags.
    always_comb begin
        wb_valid_d  = 1'b0;
        wb_rwe_d    = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        dm_err_d    = dm_err_q | acc_timeout;
        align_err_d = align_err_q | (retire_idle && m_mem && m_misaligned);
        if (retire) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = m_rd_q;
            wb_data_d  = (m_rwd_q && acc_done) ? load_data : m_alu_q;
            wb_rwe_d   = m_rwe_q && (m_rd_q != 5'd0) && !m_dmwe_q
                         && !acc_timeout && !(retire_idle && m_mem);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            m_valid_q    <= 1'b0;
            m_rd_q       <= 5'd0;
            m_alu_q      <= 32'd0;
            m_rb_q       <= 32'd0;
            m_dmwe_q     <= 1'b0;
            m_rwe_q      <= 1'b0;
            m_rwd_q      <= 1'b0;
            m_dm_byte_q  <= 1'b0;
            m_unsigned_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rwe_q     <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            dm_err_q     <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            m_valid_q    <= m_valid_d;
            m_rd_q       <= m_rd_d;
            m_alu_q      <= m_alu_d;
            m_rb_q       <= m_rb_d;
            m_dmwe_q     <= m_dmwe_d;
            m_rwe_q      <= m_rwe_d;
            m_rwd_q      <= m_rwd_d;
            m_dm_byte_q  <= m_dm_byte_d;
            m_unsigned_q <= m_unsigned_d;
            wb_valid_q   <= wb_valid_d;
            wb_rwe_q     <= wb_rwe_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            dm_err_q     <= dm_err_d;
            align_err_q  <= align_err_d;
        end
    end

    // Memory-side outputs are driven only while a request is outstanding.
    always_comb begin
        stall    = in_access;
        dm_req   = in_access;
        dm_we    = 1'b0;
        dm_addr  = 32'd0;
        dm_be    = 4'b0000;
        dm_wdata = 32'd0;
        if (in_access) begin
            dm_we   = m_dmwe_q;
            dm_addr = {m_alu_q[31:2], 2'b00};
            dm_be   = m_dm_byte_q ? (4'b1000 >> m_alu_q[1:0]) : 4'b1111;
            if (m_dmwe_q) begin
                dm_wdata = m_dm_byte_q ? {4{m_rb_q[7:0]}} : m_rb_q;
            end
        end
    end

    assign mx_bypass = m_alu_q;
    assign mx_rd     = m_rd_q;
    assign mx_rwe    = m_valid_q && m_rwe_q && (m_rd_q != 5'd0);
    assign wb_valid  = wb_valid_q;
    assign wb_rwe    = wb_rwe_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign dm_err    = dm_err_q;
    assign align_err = align_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU passthrough, word/byte loads and stores,
// misalignment, ack timeout and asynchronous reset during an access.
module tb_memory_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_insn;
  logic [31:0] in_alu;
  logic [31:0] in_rb;
  logic        in_dmwe, in_rwe, in_rdst, in_rwd, in_dm_byte, in_unsigned;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] mx_bypass;
  logic [4:0]  mx_rd;
  logic        mx_rwe;
  logic        wb_valid, wb_rwe;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dm_err, align_err;
  logic        dbg_state;

  int checks;
  int failures;
  int n;

  memory_stage #(.DM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_insn(in_insn), .in_alu(in_alu), .in_rb(in_rb),
    .in_dmwe(in_dmwe), .in_rwe(in_rwe), .in_rdst(in_rdst), .in_rwd(in_rwd),
    .in_dm_byte(in_dm_byte), .in_unsigned(in_unsigned),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mx_bypass(mx_bypass), .mx_rd(mx_rd), .mx_rwe(mx_rwe),
    .wb_valid(wb_valid), .wb_rwe(wb_rwe), .wb_rd(wb_rd), .wb_data(wb_data),
    .dm_err(dm_err), .align_err(align_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [31:0] insn, input logic [31:0] alu,
                          input logic [31:0] rb, input logic dmwe, input logic rwe,
                          input logic rdst, input logic rwd, input logic byt, input logic uns);
    in_valid    = v;
    in_insn     = insn;
    in_alu      = alu;
    in_rb       = rb;
    in_dmwe     = dmwe;
    in_rwe      = rwe;
    in_rdst     = rdst;
    in_rwd      = rwd;
    in_dm_byte  = byt;
    in_unsigned = uns;
  endtask

  task automatic drive_idle();
    drive_op(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    drive_idle();

    #2;
    check("rst_stall", stall, 0);
    check("rst_dm_req", dm_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_dm_err", dm_err, 0);
    check("rst_align_err", align_err, 0);
    check("rst_state", dbg_state, 0);
    #10 reset = 1'b1;
    step();

    // ALU passthrough, rd=5 via insn[15:11]
    drive_op(1'b1, 32'h0000_2800, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive_idle();
    check("alu_mx_bypass", mx_bypass, 32'h1234);
    check("alu_mx_rd", mx_rd, 5);
    check("alu_mx_rwe", mx_rwe, 1);
    check("alu_stall", stall, 0);
    step();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_rd", wb_rd, 5);
    check("alu_wb_data", wb_data, 32'h1234);
    check("alu_wb_rwe", wb_rwe, 1);
    step();
    check("alu_wb_valid_one", wb_valid, 0);

    // JAL forces rd=31; a stray ack in IDLE is ignored
    drive_op(1'b1, 32'h0C00_0000, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    dm_ack = 1'b1;
    step();
    drive_idle();
    check("jal_no_req", dm_req, 0);
    check("jal_mx_rd", mx_rd, 31);
    dm_ack = 1'b0;
    step();
    check("jal_wb_rd", wb_rd, 31);
    check("jal_wb_rwe", wb_rwe, 1);
    check("jal_wb_data", wb_data, 32'h40);

    // destination 0 never writes
    drive_op(1'b1, 32'h0000_0000, 32'h0000_0055, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive_idle();
    check("r0_mx_rwe", mx_rwe, 0);
    step();
    check("r0_wb_valid", wb_valid, 1);
    check("r0_wb_rwe", wb_rwe, 0);

    // LW 0x100, rt=7, ack in third ACCESS cycle
    drive_op(1'b1, 32'h0007_0000, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    check("lw_dm_addr", dm_addr, 32'h100);
    check("lw_dm_be", dm_be, 4'b1111);
    check("lw_dm_we", dm_we, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      if (i == 2) begin
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    dm_ack = 1'b0;
    check("lw_stall_cycles", n, 3);
    check("lw_stall_drop", stall, 0);
    check("lw_wb_valid", wb_valid, 1);
    check("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    check("lw_wb_rd", wb_rd, 7);
    check("lw_wb_rwe", wb_rwe, 1);
    step();
    check("lw_bubble_wb", wb_valid, 0);

    // LB 0x101 -> lane 2, sign-extended
    drive_op(1'b1, 32'h0008_0000, 32'h0000_0101, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive_idle();
    check("lb_dm_be", dm_be, 4'b0100);
    check("lb_dm_addr", dm_addr, 32'h100);
    dm_ack   = 1'b1;
    dm_rdata = 32'h11F2_3344;
    step();
    dm_ack = 1'b0;
    check("lb_wb_data", wb_data, 32'hFFFF_FFF2);
    check("lb_wb_rd", wb_rd, 8);

    // LBU 0x101 -> zero-extended
    drive_op(1'b1, 32'h0008_0000, 32'h0000_0101, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive_idle();
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    check("lbu_wb_data", wb_data, 32'h0000_00F2);

    // SB 0x203, rb=0xAB
    drive_op(1'b1, 32'h0000_2800, 32'h0000_0203, 32'h0000_00AB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive_idle();
    check("sb_dm_addr", dm_addr, 32'h200);
    check("sb_dm_be", dm_be, 4'b0001);
    check("sb_dm_wdata", dm_wdata, 32'hABAB_ABAB);
    check("sb_dm_we", dm_we, 1);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    check("sb_wb_valid", wb_valid, 1);
    check("sb_wb_rwe", wb_rwe, 0);

    // misaligned LW 0x102
    drive_op(1'b1, 32'h0007_0000, 32'h0000_0102, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    check("mis_no_req", dm_req, 0);
    check("mis_no_stall", stall, 0);
    check("mis_flag_pre", align_err, 0);
    step();
    check("mis_align_err", align_err, 1);
    check("mis_wb_valid", wb_valid, 1);
    check("mis_wb_rwe", wb_rwe, 0);

    // LW 0x300 with no ack -> timeout after 4 cycles
    drive_op(1'b1, 32'h0007_0000, 32'h0000_0300, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    n = 0;
    while (dm_req && n < 20) begin
      n++;
      step();
    end
    check("to_req_cycles", n, 4);
    check("to_dm_err", dm_err, 1);
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_rwe", wb_rwe, 0);
    check("to_stall", stall, 0);

    // next instruction proceeds
    drive_op(1'b1, 32'h0000_2800, 32'h0000_BEEF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    check("post_to_wb_valid", wb_valid, 1);
    check("post_to_wb_data", wb_data, 32'hBEEF);
    check("post_to_dm_err_sticky", dm_err, 1);

    // reset asserted mid-ACCESS
    drive_op(1'b1, 32'h0007_0000, 32'h0000_0400, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    check("mid_req_before", dm_req, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dm_req", dm_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_dm_err", dm_err, 0);
    check("mid_rst_align_err", align_err, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_no_req", dm_req, 0);
    check("mid_rst_lost", wb_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
